// File: rtl/keypad_matrix_scan_if.sv
// Keypad matrix bus: column sense in, row drive and decoded key status out.
interface keypad_matrix_scan_if #(
  parameter int unsigned N_PADS = 2,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4
);
  localparam int unsigned NK = ROWS * COLS;
  localparam int unsigned KW = (NK > 1) ? $clog2(NK) : 1;

  logic [N_PADS*COLS-1:0] cols_n;
  logic [N_PADS*ROWS-1:0] rows_n;
  logic [N_PADS*NK-1:0]   key_state;
  logic [N_PADS*KW-1:0]   keycode;
  logic [N_PADS-1:0]      key_valid;
  logic [N_PADS-1:0]      multi_key;
  logic [N_PADS-1:0]      press;
  // 'release' is a reserved word, so the release pulse carries a suffix
  logic [N_PADS-1:0]      release_evt;

  modport master (
    input  cols_n,
    output rows_n, key_state, keycode, key_valid, multi_key, press, release_evt
  );

  modport slave (
    output cols_n,
    input  rows_n, key_state, keycode, key_valid, multi_key, press, release_evt
  );
endinterface

// File: rtl/keypad_matrix_scan.sv
// Shared-timer ROWS x COLS matrix scanner for N_PADS keypads with frame
// debounce, pressed bitmap, lowest keycode, multi-key flag and press/release pulses.
module keypad_matrix_scan #(
  parameter int unsigned N_PADS   = 2,
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 1024,
  parameter int unsigned DEBOUNCE = 4
) (
  input logic                 clk,
  input logic                 rst,
  keypad_matrix_scan_if.master kp
);
  localparam int unsigned NK = ROWS * COLS;
  localparam int unsigned KW = (NK > 1) ? $clog2(NK) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned MW = $clog2(DEBOUNCE + 1);

  logic [N_PADS*COLS-1:0] sync1;
  logic [N_PADS*COLS-1:0] sync2;
  logic [SW-1:0]          slot_cnt;
  logic [RW-1:0]          row_idx;
  logic [N_PADS*ROWS-1:0] rows_q;

  logic [NK-1:0] shadow  [N_PADS];
  logic [NK-1:0] cand    [N_PADS];
  logic [MW-1:0] match   [N_PADS];
  logic [NK-1:0] state_q [N_PADS];
  logic [KW-1:0] code_q  [N_PADS];
  logic [N_PADS-1:0] valid_q;
  logic [N_PADS-1:0] multi_q;
  logic [N_PADS-1:0] press_q;
  logic [N_PADS-1:0] release_q;

  logic          running_c;
  logic          sample_c;
  logic          frame_done_c;
  logic [RW-1:0] nxt_row_c;
  logic [NK-1:0] frame_c  [N_PADS];
  logic [MW-1:0] nmatch_c [N_PADS];
  logic [KW-1:0] ncode_c  [N_PADS];
  logic [N_PADS-1:0] nvalid_c;
  logic [N_PADS-1:0] nmulti_c;
  logic [N_PADS-1:0] commit_c;

  // Row drive pattern: the selected row low on every pad, all others high.
  function automatic logic [N_PADS*ROWS-1:0] row_drive(input logic [RW-1:0] idx);
    logic [N_PADS*ROWS-1:0] v;
    v = '1;
    for (int unsigned p = 0; p < N_PADS; p++) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (RW'(r) == idx) v[p*ROWS + r] = 1'b0;
      end
    end
    return v;
  endfunction

  // All-ones row drive only exists in/just after reset: scanning has not begun.
  assign running_c    = ~(&rows_q);
  assign sample_c     = running_c && (slot_cnt == SW'(SCAN_DIV - 1));
  assign frame_done_c = sample_c && (row_idx == RW'(ROWS - 1));
  assign nxt_row_c    = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);

  // Frame view including the row sampled this cycle, plus debounce/decode next values.
  always_comb begin
    for (int unsigned p = 0; p < N_PADS; p++) begin
      frame_c[p] = shadow[p];
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (RW'(r) == row_idx) frame_c[p][r*COLS + c] = ~sync2[p*COLS + c];
        end
      end

      if (frame_c[p] != cand[p])            nmatch_c[p] = MW'(1);
      else if (match[p] >= MW'(DEBOUNCE))   nmatch_c[p] = MW'(DEBOUNCE);
      else                                  nmatch_c[p] = match[p] + MW'(1);

      commit_c[p] = frame_done_c && (nmatch_c[p] == MW'(DEBOUNCE)) &&
                    (frame_c[p] != state_q[p]);

      ncode_c[p] = code_q[p];
      for (int i = int'(NK) - 1; i >= 0; i--) begin
        if (frame_c[p][i]) ncode_c[p] = KW'(i);
      end
      nvalid_c[p] = |frame_c[p];
      nmulti_c[p] = |(frame_c[p] & (frame_c[p] - NK'(1)));
    end
  end

  // Scan timing, input synchroniser, frame capture, debounce and commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      slot_cnt  <= '0;
      row_idx   <= '0;
      rows_q    <= '1;
      valid_q   <= '0;
      multi_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int unsigned p = 0; p < N_PADS; p++) begin
        shadow[p]  <= '0;
        cand[p]    <= '0;
        match[p]   <= '0;
        state_q[p] <= '0;
        code_q[p]  <= '0;
      end
    end else begin
      sync1     <= kp.cols_n;
      sync2     <= sync1;
      press_q   <= '0;
      release_q <= '0;

      if (!running_c) begin
        rows_q <= row_drive('0);
      end else if (sample_c) begin
        slot_cnt <= '0;
        row_idx  <= nxt_row_c;
        rows_q   <= row_drive(nxt_row_c);
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end

      for (int unsigned p = 0; p < N_PADS; p++) begin
        if (sample_c) shadow[p] <= frame_c[p];
        if (frame_done_c) begin
          cand[p]  <= frame_c[p];
          match[p] <= nmatch_c[p];
        end
        if (commit_c[p]) begin
          state_q[p]   <= frame_c[p];
          code_q[p]    <= ncode_c[p];
          valid_q[p]   <= nvalid_c[p];
          multi_q[p]   <= nmulti_c[p];
          press_q[p]   <= nvalid_c[p] && (!valid_q[p] || (ncode_c[p] != code_q[p]));
          release_q[p] <= !nvalid_c[p] && valid_q[p];
        end
      end
    end
  end

  assign kp.rows_n      = rows_q;
  assign kp.key_valid   = valid_q;
  assign kp.multi_key   = multi_q;
  assign kp.press       = press_q;
  assign kp.release_evt = release_q;

  // Flatten per-pad registers onto the bus.
  for (genvar gp = 0; gp < int'(N_PADS); gp++) begin : g_pad_out
    assign kp.key_state[gp*NK +: NK] = state_q[gp];
    assign kp.keycode[gp*KW +: KW]   = code_q[gp];
  end
endmodule
